// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and flag types shared by the ALU pipeline and its combinational core

package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOTA = 3'b101,
        OP_SHL  = 3'b110,
        OP_SHR  = 3'b111
    } alu_op_e;

    // Flag part of a result; the WIDTH-bit d travels beside it so the type stays width-agnostic.
    typedef struct packed {
        logic co;
        logic zero;
        logic ovf;
    } alu_flags_t;

    // Signed overflow of x + y = r: operands agree in sign and the result disagrees.
    function automatic logic signed_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

endpackage

// File: rtl/alu_core_n.sv
// rtl/alu_core_n.sv - combinational ALU: op decode, carry, flags; ALU_SAT_EN selects signed saturation on ADD/SUB

module alu_core_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_e          i_f,
    input  logic             i_cci,
    output logic [WIDTH-1:0] o_d,
    output alu_flags_t       o_flags
);

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_arith_ovf;
    logic [WIDTH-1:0] w_d;
    logic             w_co;
    logic             w_ovf;

    // SUB reuses the adder as a + ~b + !cci, so co=1 means no borrow.
    assign w_b_eff     = (i_f == OP_SUB) ? ~i_b : i_b;
    assign w_cin       = (i_f == OP_SUB) ? ~i_cci : i_cci;
    assign w_sum       = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    assign w_arith_ovf = signed_ovf(i_a[WIDTH-1], w_b_eff[WIDTH-1], w_sum[WIDTH-1]);

    always_comb begin
        w_d   = '0;
        w_co  = 1'b0;
        w_ovf = 1'b0;
        case (i_f)
            OP_ADD, OP_SUB: begin
                w_d   = w_sum[WIDTH-1:0];
                w_co  = w_sum[WIDTH];
                w_ovf = w_arith_ovf;
`ifdef ALU_SAT_EN
                // Overflow direction follows the sign of a, which both effective operands share.
                if (w_arith_ovf) begin
                    w_d = i_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
            OP_AND:  w_d = i_a & i_b;
            OP_OR:   w_d = i_a | i_b;
            OP_XOR:  w_d = i_a ^ i_b;
            OP_NOTA: w_d = ~i_a;
            OP_SHL: begin
                w_d  = {i_a[WIDTH-2:0], i_cci};
                w_co = i_a[WIDTH-1];
            end
            OP_SHR: begin
                w_d  = {i_cci, i_a[WIDTH-1:1]};
                w_co = i_a[0];
            end
            default: ;
        endcase
    end

    assign o_d          = w_d;
    assign o_flags.co   = w_co;
    assign o_flags.zero = (w_d == '0);
    assign o_flags.ovf  = w_ovf;

endmodule

// File: rtl/alu_pipe_n.sv
// rtl/alu_pipe_n.sv - 2-stage valid/ready ALU pipeline around alu_core_n; ALU_SAT_EN enables ADD/SUB saturation

module alu_pipe_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          f,
    input  logic             cci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             co,
    output logic             zero,
    output logic             ovf
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    alu_op_e          r_s1_f;
    logic             r_s1_cci;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_d;
    alu_flags_t       r_flags;

    logic             w_s2_load;
    logic             w_s1_move;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_core_d;
    alu_flags_t       w_core_flags;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_move = r_s1_valid && w_s2_load;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_f     <= OP_ADD;
            r_s1_cci   <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_f     <= f;
            r_s1_cci   <= cci;
        end else if (w_s1_move) begin
            r_s1_valid <= 1'b0;
        end
    end

    alu_core_n #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .i_f    (r_s1_f),
        .i_cci  (r_s1_cci),
        .o_d    (w_core_d),
        .o_flags(w_core_flags)
    );

    // Result registers only change on a real beat, so they stay frozen while stalled or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_d        <= '0;
            r_flags    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_d     <= w_core_d;
                r_flags <= w_core_flags;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign d         = r_d;
    assign co        = r_flags.co;
    assign zero      = r_flags.zero;
    assign ovf       = r_flags.ovf;

endmodule

// File: tb/tb_alu_pipe_n.sv
// tb/tb_alu_pipe_n.sv - directed-vector bench for alu_pipe_n (WIDTH=8), expectations follow ALU_SAT_EN

module tb_alu_pipe_n;
    import alu_pkg::*;

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    alu_op_e    f;
    logic       cci;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       co;
    logic       zero;
    logic       ovf;

    int n_vec = 0;
    int n_bad = 0;

    alu_pipe_n #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .f        (f),
        .cci      (cci),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .co       (co),
        .zero     (zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one beat to an empty pipe; returns at the negedge where its result is visible.
    task automatic send_beat(input alu_op_e op, input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        @(negedge clk);
        in_valid = 1'b1; f = op; a = ia; b = ib; cci = ic;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; f = OP_ADD; cci = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({out_valid, d, co, zero, ovf, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state got=%h exp=%h", {out_valid, d, co, zero, ovf, in_ready}, 13'h0001);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        in_valid = 1'b1; f = OP_ADD; a = 8'hFF; b = 8'h01; cci = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL add_latency_early got=%b exp=0", out_valid);
        end
        @(negedge clk);
        n_vec++;
        if ({out_valid, d, co, zero, ovf} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL add_ff_01 got=%h exp=%h", {out_valid, d, co, zero, ovf}, {1'b1, 8'h00, 3'b110});
        end
        send_beat(OP_ADD, 8'h12, 8'h34, 1'b1);
        n_vec++;
        if ({out_valid, d, co, zero, ovf} !== {1'b1, 8'h47, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL add_cci got=%h exp=%h", {out_valid, d, co, zero, ovf}, {1'b1, 8'h47, 3'b000});
        end
    endtask

    task automatic test_sub();
        logic [7:0] exp_d;
        exp_d = SAT ? 8'h80 : 8'h7F;
        send_beat(OP_SUB, 8'h80, 8'h01, 1'b0);
        n_vec++;
        if ({out_valid, d, co, zero, ovf} !== {1'b1, exp_d, 1'b1, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL sub_80_01 got=%h exp=%h", {out_valid, d, co, zero, ovf}, {1'b1, exp_d, 3'b101});
        end
        send_beat(OP_SUB, 8'h00, 8'h01, 1'b0);
        n_vec++;
        if ({out_valid, d, co, zero, ovf} !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL sub_00_01 got=%h exp=%h", {out_valid, d, co, zero, ovf}, {1'b1, 8'hFF, 3'b000});
        end
        send_beat(OP_SUB, 8'h05, 8'h03, 1'b1);
        n_vec++;
        if ({out_valid, d, co, zero, ovf} !== {1'b1, 8'h01, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL sub_borrow_in got=%h exp=%h", {out_valid, d, co, zero, ovf}, {1'b1, 8'h01, 3'b100});
        end
    endtask

    task automatic test_logic();
        alu_op_e    ops [4] = '{OP_AND, OP_OR, OP_XOR, OP_NOTA};
        logic [7:0] va  [4] = '{8'hF0, 8'hF0, 8'hAA, 8'hFF};
        logic [7:0] vb  [4] = '{8'h3C, 8'h0C, 8'hAA, 8'h5A};
        logic [7:0] ve  [4] = '{8'h30, 8'hFC, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            send_beat(ops[i], va[i], vb[i], 1'b1);
            n_vec++;
            if ({out_valid, d, co, zero, ovf} !== {1'b1, ve[i], 1'b0, (ve[i] == 8'h00), 1'b0}) begin
                n_bad++;
                $display("FAIL logic_op%0d got=%h exp=%h", i, {out_valid, d, co, zero, ovf},
                         {1'b1, ve[i], 1'b0, (ve[i] == 8'h00), 1'b0});
            end
        end
    endtask

    task automatic test_shift();
        alu_op_e    ops [3] = '{OP_SHL, OP_SHR, OP_SHR};
        logic [7:0] va  [3] = '{8'h81, 8'h81, 8'h01};
        logic       vc  [3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] ve  [3] = '{8'h03, 8'h40, 8'h00};
        logic       vco [3] = '{1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            send_beat(ops[i], va[i], 8'hC3, vc[i]);
            n_vec++;
            if ({out_valid, d, co, zero, ovf} !== {1'b1, ve[i], vco[i], (ve[i] == 8'h00), 1'b0}) begin
                n_bad++;
                $display("FAIL shift%0d got=%h exp=%h", i, {out_valid, d, co, zero, ovf},
                         {1'b1, ve[i], vco[i], (ve[i] == 8'h00), 1'b0});
            end
        end
    endtask

    task automatic test_saturation();
        alu_op_e    ops [3] = '{OP_ADD, OP_SUB, OP_ADD};
        logic [7:0] va  [3] = '{8'h7F, 8'h80, 8'h80};
        logic [7:0] vb  [3] = '{8'h01, 8'h01, 8'h80};
        logic [7:0] wrap[3] = '{8'h80, 8'h7F, 8'h00};
        logic [7:0] sat [3] = '{8'h7F, 8'h80, 8'h80};
        logic       vco [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            e = SAT ? sat[i] : wrap[i];
            send_beat(ops[i], va[i], vb[i], 1'b0);
            n_vec++;
            if ({out_valid, d, co, zero, ovf} !== {1'b1, e, vco[i], (e == 8'h00), 1'b1}) begin
                n_bad++;
                $display("FAIL ovf_case%0d got=%h exp=%h", i, {out_valid, d, co, zero, ovf},
                         {1'b1, e, vco[i], (e == 8'h00), 1'b1});
            end
        end
    endtask

    task automatic test_back_to_back();
        alu_op_e    ops [3] = '{OP_ADD, OP_OR, OP_SUB};
        logic [7:0] va  [3] = '{8'h01, 8'h10, 8'h09};
        logic [7:0] vb  [3] = '{8'h02, 8'h01, 8'h04};
        logic [7:0] ve  [3] = '{8'h03, 8'h11, 8'h05};
        logic       vco [3] = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            n_vec++;
            if (cyc >= 2 && cyc <= 4) begin
                if ({out_valid, d, co} !== {1'b1, ve[cyc-2], vco[cyc-2]}) begin
                    n_bad++;
                    $display("FAIL b2b_beat%0d got=%h exp=%h", cyc - 2, {out_valid, d, co}, {1'b1, ve[cyc-2], vco[cyc-2]});
                end
            end else if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_idle_cyc%0d got=%b%b exp=01", cyc, out_valid, in_ready);
            end
            if (cyc < 3) begin
                in_valid = 1'b1; f = ops[cyc]; a = va[cyc]; b = vb[cyc]; cci = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ve [4] = '{8'h02, 8'h04, 8'h06, 8'h08};
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 5);
            in_valid  = (sent < 4);
            f = OP_ADD; a = 8'(sent + 1); b = 8'(sent + 1); cci = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                n_vec++;
                if ({in_ready, out_valid, d} !== {1'b0, 1'b1, 8'h02}) begin
                    n_bad++;
                    $display("FAIL stall_cyc%0d got=%h exp=%h", cyc, {in_ready, out_valid, d}, {2'b01, 8'h02});
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (d !== ve[got]) begin
                    n_bad++; $display("FAIL bp_order%0d got=%h exp=%h", got, d, ve[got]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++;
        if (got !== 4) begin
            n_bad++; $display("FAIL bp_count got=%0d exp=4", got);
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; f = OP_ADD; a = 8'h10; b = 8'h10; cci = 1'b0;
        @(negedge clk);
        a = 8'h11; b = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, d, co, zero, ovf, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL flush_state got=%h exp=%h", {out_valid, d, co, zero, ovf, in_ready}, 13'h0001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; f = OP_XOR; a = 8'h0F; b = 8'hF0; cci = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_vec++;
            if (k == 2) begin
                if ({out_valid, d} !== {1'b1, 8'hFF}) begin
                    n_bad++; $display("FAIL flush_new_beat got=%h exp=%h", {out_valid, d}, {1'b1, 8'hFF});
                end
            end else if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL flush_stale_cyc%0d got=%b d=%h exp=0", k, out_valid, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
